vga_timing_gen: RTL and testbench

- Consumes the slow square-wave output of the processor's counter-based clock divider (25 MHz level from the 50 MHz system clock).
- Samples that level in the `clk` domain and turns each rising edge into a one-cycle pixel tick.
- Each tick advances horizontal/vertical counters for 640x480@60 Hz VGA timing.
- Drives hsync, vsync, video_on and pixel coordinates to the display/pixel-fetch logic downstream.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/rise_edge_detect.sv | 22 ++
 rtl/vga_timing_gen.sv | 90 +++++++++
 tb/tb_vga_timing_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and pixel-position types for the 640x480@60 Hz display path.
package vga_timing_pkg;

    localparam int   DEF_H_VISIBLE   = 640;
    localparam int   DEF_H_FRONT     = 16;
    localparam int   DEF_H_SYNC      = 96;
    localparam int   DEF_H_BACK      = 48;
    localparam int   DEF_V_VISIBLE   = 480;
    localparam int   DEF_V_FRONT     = 10;
    localparam int   DEF_V_SYNC      = 2;
    localparam int   DEF_V_BACK      = 33;
    localparam logic DEF_SYNC_ACTIVE = 1'b0;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int COUNT_W = 10;

    typedef logic [COUNT_W-1:0] count_t;

    typedef struct packed {
        count_t x;
        count_t y;
    } pixel_pos_t;

    function automatic logic in_range(input count_t val, input count_t lo, input count_t hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Turns a level generated in the clk domain into a one-cycle pulse on each rising edge.
module rise_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic in_q;

    // Resetting high means a level that is already 1 at release is not taken as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= 1'b1;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA horizontal/vertical timing generator advanced by rising edges of the divided pixel clock level.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE   = DEF_H_VISIBLE,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_VISIBLE   = DEF_V_VISIBLE,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_src,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COUNT_W-1:0] pixel_x,
    output logic [COUNT_W-1:0] pixel_y,
    output logic               pixel_tick,
    output logic               frame_start
);

    localparam int LINE_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (LINE_TOTAL > (1 << COUNT_W) || FRAME_LINES > (1 << COUNT_W)) begin : g_total_check
        $error("vga_timing_gen: line or frame total does not fit the pixel counters");
    end

    localparam count_t H_LAST    = count_t'(LINE_TOTAL - 1);
    localparam count_t V_LAST    = count_t'(FRAME_LINES - 1);
    localparam count_t H_VIS     = count_t'(H_VISIBLE);
    localparam count_t V_VIS     = count_t'(V_VISIBLE);
    localparam count_t H_SYNC_LO = count_t'(H_VISIBLE + H_FRONT);
    localparam count_t H_SYNC_HI = count_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam count_t V_SYNC_LO = count_t'(V_VISIBLE + V_FRONT);
    localparam count_t V_SYNC_HI = count_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       edge_w;
    pixel_pos_t pos_q;
    pixel_pos_t pos_d;
    logic       pixel_tick_q;
    logic       frame_start_q;

    rise_edge_detect u_tick_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (tick_src),
        .pulse (edge_w)
    );

    always_comb begin
        pos_d = pos_q;
        if (edge_w) begin
            if (pos_q.x == H_LAST) begin
                pos_d.x = '0;
                pos_d.y = (pos_q.y == V_LAST) ? '0 : pos_q.y + 1'b1;
            end else begin
                pos_d.x = pos_q.x + 1'b1;
            end
        end
    end

    // Pulses are registered so they line up with the first cycle showing the new position.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q         <= '0;
            pixel_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pos_q         <= pos_d;
            pixel_tick_q  <= edge_w;
            frame_start_q <= edge_w && (pos_d.x == '0) && (pos_d.y == '0);
        end
    end

    assign pixel_x     = pos_q.x;
    assign pixel_y     = pos_q.y;
    assign pixel_tick  = pixel_tick_q;
    assign frame_start = frame_start_q;

    assign hsync    = (!rst && in_range(pos_q.x, H_SYNC_LO, H_SYNC_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vsync    = (!rst && in_range(pos_q.y, V_SYNC_LO, V_SYNC_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign video_on = (pos_q.x < H_VIS) && (pos_q.y < V_VIS) && !rst;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size generator for line timing, plus a shrunken-timing copy for frame wrap.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_src = 1'b0;

    always #5 clk = ~clk;

    logic       hsync, vsync, video_on, pixel_tick, frame_start;
    logic [9:0] pixel_x, pixel_y;
    logic       hsync_s, vsync_s, video_on_s, pixel_tick_s, frame_start_s;
    logic [9:0] pixel_x_s, pixel_y_s;

    int n_checks = 0;
    int n_fail   = 0;

    vga_timing_gen dut (
        .clk         (clk),
        .rst         (rst),
        .tick_src    (tick_src),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_tick  (pixel_tick),
        .frame_start (frame_start)
    );

    // Small timing: line of 16 (hsync x 10..12), frame of 10 lines (vsync y 6..7).
    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_VISIBLE (4), .V_FRONT (2), .V_SYNC (2), .V_BACK (2),
        .SYNC_ACTIVE (1'b0)
    ) dut_s (
        .clk         (clk),
        .rst         (rst),
        .tick_src    (tick_src),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .video_on    (video_on_s),
        .pixel_x     (pixel_x_s),
        .pixel_y     (pixel_y_s),
        .pixel_tick  (pixel_tick_s),
        .frame_start (frame_start_s)
    );

    task automatic do_reset(input logic src);
        rst = 1'b1;
        tick_src = src;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_src();
        tick_src = 1'b1;
        @(negedge clk);
        tick_src = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick_src = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_src = ~tick_src;
            @(negedge clk);
            n_checks++;
            if ({pixel_x, pixel_y, hsync, vsync, video_on, pixel_tick, frame_start} !==
                {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got x=%0d y=%0d hs=%b vs=%b von=%b tick=%b fs=%b, expected x=0 y=0 hs=1 vs=1 von=0 tick=0 fs=0",
                         i, pixel_x, pixel_y, hsync, vsync, video_on, pixel_tick, frame_start);
            end
        end
        rst = 1'b0;
        tick_src = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({video_on, video_on_s, pixel_x, pixel_y, pixel_tick, hsync} !== {1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release: got von=%b von_s=%b x=%0d y=%0d tick=%b hs=%b, expected von=1 von_s=1 x=0 y=0 tick=0 hs=1",
                     video_on, video_on_s, pixel_x, pixel_y, pixel_tick, hsync);
        end
    endtask

    task automatic test_fastest();
        for (int k = 1; k <= 4; k++) begin
            tick_src = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({pixel_tick, pixel_x} !== {1'b1, 10'(k)}) begin
                n_fail++;
                $display("FAIL fastest_tick[%0d]: got tick=%b x=%0d, expected tick=1 x=%0d", k, pixel_tick, pixel_x, k);
            end
            tick_src = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({pixel_tick, pixel_x} !== {1'b0, 10'(k)}) begin
                n_fail++;
                $display("FAIL fastest_gap[%0d]: got tick=%b x=%0d, expected tick=0 x=%0d", k, pixel_tick, pixel_x, k);
            end
        end
    endtask

    task automatic test_line();
        int   hs_low;
        int   ex, ey;
        logic ehs, evo;
        hs_low = 0;
        do_reset(1'b0);
        for (int t = 1; t <= 1600; t++) begin
            pulse_src();
            ex  = t % 800;
            ey  = t / 800;
            ehs = (ex >= 656 && ex <= 751) ? 1'b0 : 1'b1;
            evo = (ex < 640) && (ey < 480);
            if (hsync === 1'b0) hs_low++;
            n_checks++;
            if ({pixel_x, pixel_y, hsync, vsync, video_on} !== {10'(ex), 10'(ey), ehs, 1'b1, evo}) begin
                n_fail++;
                $display("FAIL line_tick[%0d]: got x=%0d y=%0d hs=%b vs=%b von=%b, expected x=%0d y=%0d hs=%b vs=1 von=%b",
                         t, pixel_x, pixel_y, hsync, vsync, video_on, ex, ey, ehs, evo);
            end
        end
        n_checks++;
        if (hs_low != 192) begin
            n_fail++;
            $display("FAIL line_hsync_width: got %0d low ticks over two lines, expected 192", hs_low);
        end
    endtask

    task automatic test_frame();
        int   fs_cnt, fs_main;
        int   ex, ey;
        logic ehs, evs, evo;
        fs_cnt = 0;
        fs_main = 0;
        do_reset(1'b0);
        for (int t = 1; t <= 160; t++) begin
            tick_src = 1'b1;
            @(negedge clk);
            if (frame_start === 1'b1) fs_main++;
            if (frame_start_s === 1'b1) begin
                fs_cnt++;
                n_checks++;
                if ({pixel_x_s, pixel_y_s} !== {10'd0, 10'd0}) begin
                    n_fail++;
                    $display("FAIL frame_start_pos: got x=%0d y=%0d, expected x=0 y=0", pixel_x_s, pixel_y_s);
                end
            end
            tick_src = 1'b0;
            @(negedge clk);
            ex  = t % 16;
            ey  = (t / 16) % 10;
            ehs = (ex >= 10 && ex <= 12) ? 1'b0 : 1'b1;
            evs = (ey == 6 || ey == 7) ? 1'b0 : 1'b1;
            evo = (ex < 8) && (ey < 4);
            n_checks++;
            if ({pixel_x_s, pixel_y_s, hsync_s, vsync_s, video_on_s} !== {10'(ex), 10'(ey), ehs, evs, evo}) begin
                n_fail++;
                $display("FAIL frame_tick[%0d]: got x=%0d y=%0d hs=%b vs=%b von=%b, expected x=%0d y=%0d hs=%b vs=%b von=%b",
                         t, pixel_x_s, pixel_y_s, hsync_s, vsync_s, video_on_s, ex, ey, ehs, evs, evo);
            end
        end
        n_checks++;
        if (fs_cnt != 1 || fs_main != 0) begin
            n_fail++;
            $display("FAIL frame_start_count: got small=%0d full=%0d, expected small=1 full=0", fs_cnt, fs_main);
        end
    endtask

    task automatic test_stall();
        do_reset(1'b1);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) tick_src = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({pixel_tick, pixel_tick_s, pixel_x, pixel_y} !== {1'b0, 1'b0, 10'd0, 10'd0}) begin
                n_fail++;
                $display("FAIL stall[%0d]: got tick=%b tick_s=%b x=%0d y=%0d, expected tick=0 tick_s=0 x=0 y=0",
                         i, pixel_tick, pixel_tick_s, pixel_x, pixel_y);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b0);
        for (int t = 0; t < 53; t++) pulse_src();
        n_checks++;
        if ({pixel_x_s, pixel_y_s, pixel_x, pixel_y} !== {10'd5, 10'd3, 10'd53, 10'd0}) begin
            n_fail++;
            $display("FAIL midreset_setup: got small=(%0d,%0d) full=(%0d,%0d), expected small=(5,3) full=(53,0)",
                     pixel_x_s, pixel_y_s, pixel_x, pixel_y);
        end
        tick_src = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({pixel_x, pixel_y, pixel_x_s, pixel_y_s, pixel_tick, pixel_tick_s, frame_start, frame_start_s, video_on, hsync_s}
            !== {10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_edge: got full=(%0d,%0d) small=(%0d,%0d) tick=%b/%b fs=%b/%b von=%b hs_s=%b, expected (0,0) (0,0) tick=0/0 fs=0/0 von=0 hs_s=1",
                     pixel_x, pixel_y, pixel_x_s, pixel_y_s, pixel_tick, pixel_tick_s, frame_start, frame_start_s, video_on, hsync_s);
        end
        rst = 1'b0;
        tick_src = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({video_on, frame_start, frame_start_s, pixel_tick, pixel_x_s, pixel_y_s} !== {1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL midreset_release: got von=%b fs=%b fs_s=%b tick=%b small=(%0d,%0d), expected von=1 fs=0 fs_s=0 tick=0 small=(0,0)",
                     video_on, frame_start, frame_start_s, pixel_tick, pixel_x_s, pixel_y_s);
        end
    endtask

    initial begin
        test_reset();
        test_fastest();
        test_line();
        test_frame();
        test_stall();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
